// File: rtl/ddc_mixer_cic.sv
// ddc_mixer_cic: I/Q mixer followed by a 3-stage CIC decimator per branch, one output pair per DECIMATION samples.
// Define DDC_MIXER_CIC_ROUND_EN for round-half-up with positive saturation instead of truncation.
module ddc_mixer_cic #(
  parameter int DATA_WIDTH = 12,
  parameter int DECIMATION = 64,
  parameter int ACC_WIDTH  = 42,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         sample_clk_ce,
  input  logic signed [DATA_WIDTH-1:0] adc_sample,
  input  logic signed [DATA_WIDTH-1:0] lo_cos,
  input  logic signed [DATA_WIDTH-1:0] lo_sin,
  output logic signed [OUT_WIDTH-1:0]  i_out,
  output logic signed [OUT_WIDTH-1:0]  q_out,
  output logic                         out_valid
);
  localparam int MW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DECIMATION);
  localparam int AW = ACC_WIDTH;
  localparam int OW = OUT_WIDTH;
  logic [1:0][MW-1:0]       mix_q, mix_d;
  logic [1:0][2:0][AW-1:0]  int_q, int_d, dly_q, dly_d, c;
  logic [1:0][OW-1:0]       out_q, out_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     valid_q, valid_d, tick;
`ifdef DDC_MIXER_CIC_ROUND_EN
  logic [1:0][AW-1:0]       rnd;
`endif
  always_comb begin
    tick = sample_clk_ce && (cnt_q == CW'(DECIMATION - 1));
    cnt_d = sample_clk_ce ? (tick ? '0 : cnt_q + 1'b1) : cnt_q;
    valid_d = tick;
    mix_d[0] = adc_sample * lo_cos;
    mix_d[1] = -(adc_sample * lo_sin);
`ifdef DDC_MIXER_CIC_ROUND_EN
    rnd = '0;
`endif
    for (int b = 0; b < 2; b++) begin
      int_d[b][0] = int_q[b][0] + {{(AW-MW){mix_q[b][MW-1]}}, mix_q[b]};
      int_d[b][1] = int_q[b][1] + int_q[b][0];
      int_d[b][2] = int_q[b][2] + int_q[b][1];
      c[b][0] = int_q[b][2] - dly_q[b][0];
      c[b][1] = c[b][0] - dly_q[b][1];
      c[b][2] = c[b][1] - dly_q[b][2];
      dly_d[b][0] = int_q[b][2];
      dly_d[b][1] = c[b][0];
      dly_d[b][2] = c[b][1];
`ifdef DDC_MIXER_CIC_ROUND_EN
      rnd[b] = c[b][2] + (AW'(1) << (AW - OW - 1));
      // A positive value that turns negative after the half-LSB add has overflowed
      out_d[b] = (!c[b][2][AW-1] && rnd[b][AW-1]) ? {1'b0, {(OW-1){1'b1}}} : rnd[b][AW-1 -: OW];
`else
      out_d[b] = c[b][2][AW-1 -: OW];
`endif
    end
  end
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mix_q   <= '0;
      int_q   <= '0;
      dly_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (sample_clk_ce) begin
        mix_q <= mix_d;
        int_q <= int_d;
        cnt_q <= cnt_d;
        if (tick) begin
          dly_q <= dly_d;
          out_q <= out_d;
        end
      end
    end
  end
  assign i_out     = out_q[0];
  assign q_out     = out_q[1];
  assign out_valid = valid_q;
endmodule
